// File: rtl/xor_frame_parity_pkg.sv
// xor_frame_parity_pkg: shared FSM state encodings and parity default for xor_frame_parity
package xor_frame_parity_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int ODD_PARITY_DEFAULT = 0;

endpackage

// File: rtl/xor_frame_parity_xor_reduce.sv
// xor_reduce: combinational WIDTH-bit XOR reduction with optional inversion (generalised nested-XOR mux)
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             inv,
    output logic             par
);

    assign par = (^vec) ^ inv;

endmodule

// File: rtl/xor_frame_parity.sv
// xor_frame_parity: per-frame column XOR, parity and beat count; optional parity check via XOR_FRAME_PARITY_CHECK_EN
module xor_frame_parity
    import xor_frame_parity_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CNT_W      = 8,
    parameter int ODD_PARITY = ODD_PARITY_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_col_xor,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
`ifdef XOR_FRAME_PARITY_CHECK_EN
    ,
    input  logic             in_parity,
    output logic             out_err
`endif
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] next_acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             accept;

    assign in_ready    = state != HOLD;
    assign out_valid   = state == HOLD;
    assign accept      = in_valid & in_ready;
    assign out_col_xor = acc;
    assign out_count   = count;

    // Next accumulator/count for an accepted word; the first beat restarts the frame
    always_comb begin
        next_acc   = state == IDLE ? in_data : acc ^ in_data;
        next_count = state == IDLE ? CNT_W'(1) : (&count ? count : count + CNT_W'(1));
    end

    xor_reduce #(.WIDTH(WIDTH)) u_out_par (
        .vec (acc),
        .inv (1'(ODD_PARITY)),
        .par (out_parity)
    );

`ifdef XOR_FRAME_PARITY_CHECK_EN
    logic next_par;

    xor_reduce #(.WIDTH(WIDTH)) u_next_par (
        .vec (next_acc),
        .inv (1'(ODD_PARITY)),
        .par (next_par)
    );

    // Error flag captured with the last word, cleared when the result is consumed
    always_ff @(posedge clk) begin
        if (rst)
            out_err <= 1'b0;
        else if (accept && in_last)
            out_err <= in_parity != next_par;
        else if (out_valid && out_ready)
            out_err <= 1'b0;
    end
`endif

    // Frame FSM: accumulate accepted words, hold the result until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            count <= '0;
        end else if (accept) begin
            acc   <= next_acc;
            count <= next_count;
            state <= in_last ? HOLD : ACCUM;
        end else if (out_valid && out_ready) begin
            state <= IDLE;
        end
    end

endmodule

// File: tb/tb_xor_frame_parity.sv
// tb_xor_frame_parity: directed self-checking bench for xor_frame_parity (three parameterisations, shared stimulus)
module tb_xor_frame_parity;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_parity = 1'b0;

    logic       rdy0, rdy1, rdy2;
    logic       vld0, vld1, vld2;
    logic [7:0] col0, col1, col2;
    logic       par0, par1, par2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
`ifdef XOR_FRAME_PARITY_CHECK_EN
    logic       err0, err1, err2;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xor_frame_parity #(.WIDTH(8), .CNT_W(8), .ODD_PARITY(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_data(in_data),
        .in_last(in_last), .out_valid(vld0), .out_ready(out_ready), .out_col_xor(col0),
        .out_parity(par0), .out_count(cnt0)
`ifdef XOR_FRAME_PARITY_CHECK_EN
        , .in_parity(in_parity), .out_err(err0)
`endif
    );

    xor_frame_parity #(.WIDTH(8), .CNT_W(8), .ODD_PARITY(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_data(in_data),
        .in_last(in_last), .out_valid(vld1), .out_ready(out_ready), .out_col_xor(col1),
        .out_parity(par1), .out_count(cnt1)
`ifdef XOR_FRAME_PARITY_CHECK_EN
        , .in_parity(in_parity), .out_err(err1)
`endif
    );

    xor_frame_parity #(.WIDTH(8), .CNT_W(2), .ODD_PARITY(0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_data(in_data),
        .in_last(in_last), .out_valid(vld2), .out_ready(out_ready), .out_col_xor(col2),
        .out_parity(par2), .out_count(cnt2)
`ifdef XOR_FRAME_PARITY_CHECK_EN
        , .in_parity(in_parity), .out_err(err2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_valid", 32'(vld0), 0);
        chk("rst_ready", 32'(rdy0), 1);
        chk("rst_col", 32'(col0), 0);
        chk("rst_cnt", 32'(cnt0), 0);
        chk("rst_par_even", 32'(par0), 0);
        chk("rst_par_odd", 32'(par1), 1);

        in_valid = 1'b1; in_data = 8'hA5; in_last = 1'b0;
        tick();
        in_data = 8'h3C;
        tick();
        chk("f1_not_yet_valid", 32'(vld0), 0);
        chk("f1_running_cnt", 32'(cnt0), 2);
        in_data = 8'h0F; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("f1_valid", 32'(vld0), 1);
        chk("f1_col", 32'(col0), 32'h96);
        chk("f1_par_even", 32'(par0), 0);
        chk("f1_par_odd", 32'(par1), 1);
        chk("f1_cnt", 32'(cnt0), 3);
        chk("f1_cnt_sat", 32'(cnt2), 3);

        in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_ready", 32'(rdy0), 0);
            chk("hold_valid", 32'(vld0), 1);
            chk("hold_col", 32'(col0), 32'h96);
            chk("hold_cnt", 32'(cnt0), 3);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("release_valid", 32'(vld0), 0);
        chk("release_ready", 32'(rdy0), 1);
        chk("release_col_held", 32'(col0), 32'h96);

        in_data = 8'hAA; in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("last_no_valid_ignored", 32'(vld0), 0);
        chk("last_no_valid_col", 32'(col0), 32'h96);

        in_valid = 1'b1; in_data = 8'h01; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("single_valid", 32'(vld1), 1);
        chk("single_col", 32'(col1), 32'h01);
        chk("single_par_odd", 32'(par1), 0);
        chk("single_par_even", 32'(par0), 1);
        chk("single_cnt", 32'(cnt1), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        in_valid = 1'b1; in_data = 8'h12;
        tick();
        in_data = 8'h34;
        tick();
        in_valid = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cnt", 32'(cnt0), 0);
        chk("midrst_col", 32'(col0), 0);
        chk("midrst_ready", 32'(rdy0), 1);
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("ff_valid", 32'(vld0), 1);
        chk("ff_col", 32'(col0), 32'hFF);
        chk("ff_cnt", 32'(cnt0), 1);
        chk("ff_par", 32'(par0), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 8'(1 << i);
            in_last = (i == 4);
            tick();
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("sat_valid", 32'(vld2), 1);
        chk("sat_col", 32'(col2), 32'h1F);
        chk("sat_cnt2", 32'(cnt2), 3);
        chk("sat_cnt8", 32'(cnt0), 5);
        chk("sat_par", 32'(par2), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

`ifdef XOR_FRAME_PARITY_CHECK_EN
        in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1; in_parity = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; in_parity = 1'b0;
        chk("err_set", 32'(err0), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("err_cleared", 32'(err0), 0);
        in_valid = 1'b1; in_data = 8'h03; in_last = 1'b1; in_parity = 1'b0;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        chk("err_clear_match", 32'(err0), 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
